// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-wide instruction fetch with 16-bit assembly and a small decode queue
// Two-state fetch (LO/HI) fills a circular FIFO; redirect flushes everything and reloads fetch_pc.
module fetch_unit #(
    parameter int          QDEPTH   = 2,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_rd,
    output logic [7:0]  mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [15:0] ins,
    output logic [7:0]  ins_pc,
    input  logic        redirect,
    input  logic [7:0]  redirect_pc,
    input  logic        halt,
    output logic [7:0]  fetch_pc
);

    localparam int PW = (QDEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

    localparam logic [0:0] ST_LO = 1'b0;
    localparam logic [0:0] ST_HI = 1'b1;

    logic [0:0]    state_q, state_d;
    logic          started_q;
    logic [7:0]    fetch_pc_q, fetch_pc_d;
    logic [7:0]    lo_byte_q, lo_byte_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   q_ins_q [QDEPTH];
    logic [7:0]    q_pc_q  [QDEPTH];

    logic start_lo;
    logic push;
    logic pop;

    // The LO entry check reserves a queue slot, so a HI push never overflows.
    assign start_lo  = started_q && (count_q < DEPTH_C) && !halt;
    assign ins_valid = (count_q != '0);
    assign pop       = ins_valid && ins_ready;
    assign push      = (state_q == ST_HI) && !redirect;
    assign fetch_pc  = fetch_pc_q;

    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = 8'h00;
        if (state_q == ST_HI) begin
            mem_rd   = 1'b1;
            mem_addr = fetch_pc_q + 8'd1;
        end else if (start_lo) begin
            mem_rd   = 1'b1;
            mem_addr = fetch_pc_q;
        end
    end

    always_comb begin
        ins    = 16'h0000;
        ins_pc = 8'h00;
        if (ins_valid) begin
            ins    = q_ins_q[rd_ptr_q];
            ins_pc = q_pc_q[rd_ptr_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        lo_byte_d  = lo_byte_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (redirect) begin
            // A pop on this edge still counts as consumed; the flush wins for everything else.
            state_d    = ST_LO;
            fetch_pc_d = redirect_pc;
            lo_byte_d  = 8'h00;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            case (state_q)
                ST_LO: begin
                    if (start_lo) begin
                        lo_byte_d = mem_rdata;
                        state_d   = ST_HI;
                    end
                end
                default: begin
                    fetch_pc_d = fetch_pc_q + 8'd2;
                    state_d    = ST_LO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LO;
            started_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            lo_byte_q  <= 8'h00;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            started_q  <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            lo_byte_q  <= lo_byte_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_ins_q[i] <= 16'h0000;
                q_pc_q[i]  <= 8'h00;
            end
        end else if (push) begin
            q_ins_q[wr_ptr_q] <= {mem_rdata, lo_byte_q};
            q_pc_q[wr_ptr_q]  <= fetch_pc_q;
        end
    end

endmodule
